// File: rtl/inst_fetch.sv
// Instruction-fetch stage: fetch PC, 1-cycle synchronous imem reads, 2-entry response queue, decode redirects.
// Optional build macro INST_FETCH_BUBBLE_CNT_EN adds a saturating bubble_cnt output.
module inst_fetch #(
  parameter int          INST_MEM_WIDTH = 2,
  parameter int unsigned RESET_PC       = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic [INST_MEM_WIDTH-1:0] imem_addr,
  output logic                      imem_en,
  input  logic [31:0]               imem_data,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [INST_MEM_WIDTH-1:0] redirect_pc,
  output logic                      valid,
  output logic [31:0]               inst,
  output logic [INST_MEM_WIDTH-1:0] pc,
  output logic [INST_MEM_WIDTH-1:0] pc1
`ifdef INST_FETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0]               bubble_cnt
`endif
);

  localparam int W = INST_MEM_WIDTH;
  localparam logic [W-1:0] RESET_ADDR = RESET_PC[W-1:0];

  function automatic logic [W-1:0] pc_inc(input logic [W-1:0] p);
    return p + W'(1);
  endfunction

  logic [W-1:0]  fetch_pc;
  logic          inflight;
  logic [W-1:0]  inflight_pc;
  logic [1:0]    count;
  logic [31:0]   q0_inst, q1_inst;
  logic [W-1:0]  q0_pc, q1_pc;

  logic          pop;
  logic          push;
  logic [2:0]    occ;
  logic [1:0]    wr_slot;

  // Issue side: the occupancy after this edge must leave room for the response of a new read
  always_comb begin
    valid     = (count != 2'd0);
    pop       = valid & ~stall & ~redirect;
    push      = inflight & ~redirect;
    occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    imem_en   = reset_n & (redirect | (occ < 3'd2));
    imem_addr = redirect ? redirect_pc : fetch_pc;
    wr_slot   = count - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_ADDR;
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= imem_en;
      if (imem_en)
        fetch_pc <= pc_inc(imem_addr);
      if (redirect)
        count <= 2'd0;
      else
        count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Response side: queue payload is qualified by count, so it carries no reset
  always_ff @(posedge clk) begin
    if (imem_en)
      inflight_pc <= imem_addr;
    if (pop) begin
      q0_inst <= q1_inst;
      q0_pc   <= q1_pc;
    end
    if (push) begin
      if (wr_slot == 2'd0) begin
        q0_inst <= imem_data;
        q0_pc   <= inflight_pc;
      end else begin
        q1_inst <= imem_data;
        q1_pc   <= inflight_pc;
      end
    end
  end

  always_comb begin
    inst = valid ? q0_inst : 32'h0;
    pc   = valid ? q0_pc : '0;
    pc1  = valid ? pc_inc(q0_pc) : '0;
  end

`ifdef INST_FETCH_BUBBLE_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bubble_cnt <= 32'd0;
    else if (!valid)
      bubble_cnt <= sat_inc(bubble_cnt);
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural 1-cycle imem and a scoreboard of expected PCs.
module tb_inst_fetch;
  localparam int W = 2;

  logic          clk = 1'b0;
  logic          reset_n, stall, redirect;
  logic [W-1:0]  redirect_pc;
  logic [W-1:0]  imem_addr;
  logic          imem_en;
  logic [31:0]   imem_data = 32'h0;
  logic          valid;
  logic [31:0]   inst;
  logic [W-1:0]  pc, pc1;
`ifdef INST_FETCH_BUBBLE_CNT_EN
  logic [31:0]   bubble_cnt;
`endif

  logic [31:0]   mem [4];
  logic [W-1:0]  sb [$];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_en) imem_data <= mem[imem_addr];

  inst_fetch #(.INST_MEM_WIDTH(W), .RESET_PC(0)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .imem_addr(imem_addr),
    .imem_en(imem_en),
    .imem_data(imem_data),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .valid(valid),
    .inst(inst),
    .pc(pc),
    .pc1(pc1)
`ifdef INST_FETCH_BUBBLE_CNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_pc"}, {30'b0, pc}, 32'd0);
    chk({tag, "_pc1"}, {30'b0, pc1}, 32'd0);
  endtask

  task automatic expect_head(input string tag, input bit consume);
    logic [W-1:0] e, e1;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() == 0) return;
    e = sb[0];
    if (consume) void'(sb.pop_front());
    e1 = e + 2'd1;
    chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
    chk({tag, "_pc"}, {30'b0, pc}, {30'b0, e});
    chk({tag, "_inst"}, inst, mem[e]);
    chk({tag, "_pc1"}, {30'b0, pc1}, {30'b0, e1});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[0] = 32'h00c21004;
    mem[1] = 32'h00650458;
    mem[2] = 32'h11111111;
    mem[3] = 32'h22222222;
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    repeat (2) next_cycle();
    expect_idle("rst");
    chk("rst_en", {31'b0, imem_en}, 32'd0);
`ifdef INST_FETCH_BUBBLE_CNT_EN
    chk("rst_bubble", bubble_cnt, 32'd0);
`endif

    // Reset release: first fetch at pc 0, valid two cycles later
    reset_n = 1'b1;
    settle();
    chk("c0_en", {31'b0, imem_en}, 32'd1);
    chk("c0_addr", {30'b0, imem_addr}, 32'd0);
    chk("c0_valid", {31'b0, valid}, 32'd0);
    next_cycle();
    chk("c1_valid", {31'b0, valid}, 32'd0);
    sb.push_back(2'd0); sb.push_back(2'd1); sb.push_back(2'd2);
    sb.push_back(2'd3); sb.push_back(2'd0); sb.push_back(2'd1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      expect_head("seq", 1'b1);
    end

    // Stall three cycles on pc 1
    next_cycle();
    stall = 1'b1;
    settle();
    expect_head("stall0", 1'b0);
    chk("stall0_en", {31'b0, imem_en}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      expect_head("stall", 1'b0);
      chk("stall_full_en", {31'b0, imem_en}, 32'd0);
    end
    next_cycle();
    stall = 1'b0;
    settle();
    expect_head("release", 1'b1);
    sb.push_back(2'd2); sb.push_back(2'd3); sb.push_back(2'd0);
    next_cycle(); expect_head("post_stall", 1'b1);
    next_cycle(); expect_head("post_stall", 1'b1);

    // Redirect to 3 while pc 0 is shown
    next_cycle();
    redirect = 1'b1; redirect_pc = 2'd3;
    settle();
    chk("redir_en", {31'b0, imem_en}, 32'd1);
    chk("redir_addr", {30'b0, imem_addr}, 32'd3);
    expect_head("redir_br", 1'b1);
    next_cycle();
    redirect = 1'b0;
    settle();
    chk("redir_bubble", {31'b0, valid}, 32'd0);
    sb.push_back(2'd3); sb.push_back(2'd0); sb.push_back(2'd1);
    next_cycle(); expect_head("redir_tgt", 1'b1);
    next_cycle(); expect_head("redir_seq", 1'b1);
`ifdef INST_FETCH_BUBBLE_CNT_EN
    chk("bubble_cnt", bubble_cnt, 32'd3);
`endif

    // Redirect with stall, target 2
    next_cycle();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 2'd2;
    settle();
    chk("rs_en", {31'b0, imem_en}, 32'd1);
    chk("rs_addr", {30'b0, imem_addr}, 32'd2);
    expect_head("rs_br", 1'b1);
    next_cycle();
    stall = 1'b0; redirect = 1'b0;
    settle();
    chk("rs_bubble", {31'b0, valid}, 32'd0);
    sb.push_back(2'd2); sb.push_back(2'd3); sb.push_back(2'd0);
    next_cycle(); expect_head("rs_tgt", 1'b1);
    next_cycle(); expect_head("rs_seq", 1'b1);

    // Fill the queue, then reset asynchronously mid-cycle
    next_cycle();
    stall = 1'b1;
    settle();
    expect_head("fill", 1'b0);
    next_cycle();
    expect_head("full", 1'b0);
    chk("full_en", {31'b0, imem_en}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    expect_idle("mid_rst");
    chk("mid_rst_en", {31'b0, imem_en}, 32'd0);
`ifdef INST_FETCH_BUBBLE_CNT_EN
    chk("mid_rst_bubble", bubble_cnt, 32'd0);
`endif
    sb.delete();
    stall = 1'b0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    settle();
    chk("re_c0_en", {31'b0, imem_en}, 32'd1);
    chk("re_c0_addr", {30'b0, imem_addr}, 32'd0);
    chk("re_c0_valid", {31'b0, valid}, 32'd0);
    next_cycle();
    chk("re_c1_valid", {31'b0, valid}, 32'd0);
    sb.push_back(2'd0); sb.push_back(2'd1); sb.push_back(2'd2);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      expect_head("restart", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the core, directly upstream of `inst_decode`. Keeps the fetch PC and issues word reads to a synchronous-read instruction memory with one-cycle latency. Buffers returned words in a 2-entry queue so a downstream stall never loses an in-flight fetch. Presents `inst`/`pc`/`pc1` with a valid flag, and accepts PC redirects (branch/jump) from decode.

## Interface
- `INST_MEM_WIDTH`, 2, PC/address width in words; also the width of `pc`, `pc1` and the redirect target.
- `RESET_PC`, 0, first address fetched after reset.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  INST_MEM_WIDTH  read address, combinational.
- `imem_en`  out  1  read request this cycle, combinational.
- `imem_data`  in  32  read data for the address requested in the previous cycle.
- `stall`  in  1  decode cannot accept the presented instruction this cycle.
- `redirect`  in  1  decode requests a PC change; overrides `stall`.
- `redirect_pc`  in  INST_MEM_WIDTH  new fetch address (decode's `pc_next`).
- `valid`  out  1  `inst`/`pc`/`pc1` hold a real instruction.
- `inst`  out  32  instruction word at queue head.
- `pc`  out  INST_MEM_WIDTH  address of `inst`.
- `pc1`  out  INST_MEM_WIDTH  `pc + 1`, modulo 2^INST_MEM_WIDTH.

## Operation
- State:
  - `fetch_pc`: next sequential address.
  - `inflight` flag plus `inflight_pc`.
  - 2-entry FIFO of {inst, pc}, with `count` in 0..2.
- `pop = valid & ~stall & ~redirect`: the head is consumed and removed.
- A redirect also consumes the displayed instruction, which is the branch itself.
- Issue rule:
  - `imem_en = redirect | (count + inflight - pop < 2)`.
  - `imem_en` is forced to 0 while `reset_n` is low.
- Address:
  - `imem_addr = redirect ? redirect_pc : fetch_pc`.
  - On issue, `fetch_pc <= imem_addr + 1`, wrapping modulo 2^W.
- Response:
  - If `inflight` is set and there is no redirect this cycle, {`imem_data`, `inflight_pc`} is pushed into the FIFO at the edge.
  - Push and pop in the same cycle are allowed.
  - The issue rule guarantees a push never hits a full FIFO.
- Redirect, sampled in cycle n:
  - FIFO is flushed to `count = 0`.
  - The response arriving in cycle n is discarded.
  - `inflight_pc <= redirect_pc`.
- `redirect` together with `stall`: the redirect wins.
- Output view:
  - `valid = (count != 0)`.
  - When `valid` = 1: `inst`/`pc` come from the head entry and `pc1 = pc + 1`.
  - When `valid` = 0: `inst` = 32'h0 (NOP) and `pc` = `pc1` = 0.
- Reset, asynchronous, also mid-operation:
  - `fetch_pc = RESET_PC`, `inflight = 0`, `count = 0`.
  - Hence `valid` = 0, `inst` = 0, `pc` = 0, `pc1` = 0.
  - Any in-flight response is dropped.

## Timing
- After reset release:
  - First cycle: `imem_en` = 1, `imem_addr` = `RESET_PC`.
  - `valid` rises two cycles later with `inst` = mem[`RESET_PC`].
- Steady state without stall: one instruction per cycle, sequential PCs.
- Redirect in cycle n:
  - `valid` = 0 in cycle n+1.
  - In cycle n+2: `valid` = 1, `pc` = `redirect_pc`, `inst` = mem[`redirect_pc`].
  - The redirect penalty is therefore 1 bubble.
- Stall held for k cycles:
  - Outputs stay frozen.
  - The FIFO fills to 2, and `imem_en` drops once `count + inflight` = 2.
  - When the stall is released, instructions continue back-to-back with no bubble.
- PC wrap: with W = 2, the next address after pc 3 is pc 0 and `pc1` of pc 3 is 0.

## Configuration
- `INST_FETCH_BUBBLE_CNT_EN`
  - Defined: adds output `bubble_cnt` [31:0].
    - Reset to 0.
    - Increments every cycle with `reset_n` high and `valid` = 0.
    - Saturates at 32'hFFFF_FFFF.
  - Undefined: the port and the counter logic are absent; all other behaviour is identical.

## Test plan
All scenarios use W = 2, `RESET_PC` = 0, and mem = {0: 32'h00c21004, 1: 32'h00650458, 2: 32'h11111111, 3: 32'h22222222}.

- Reset release, no stall:
  - `valid` goes high 2 cycles after release.
  - Sequence is pc 0,1,2,3,0 with inst 00c21004, 00650458, 11111111, 22222222, 00c21004.
  - `pc1` = 1,2,3,0,1.
- Stall for 3 cycles while pc 1 is presented:
  - pc 1 / 00650458 is held throughout the stall.
  - `imem_en` = 0 once the FIFO is full.
  - After release: pc 2, then pc 3, on consecutive cycles.
- Redirect to 3 while pc 0 is presented:
  - Next cycle `valid` = 0.
  - Following cycle pc 3 / 22222222, then pc 0.
  - pc 1 never appears.
- `redirect` and `stall` together, target 2:
  - Stall is ignored and the FIFO is flushed.
  - pc 2 / 11111111 appears 2 cycles later.
- Assert `reset_n` low mid-stream with the FIFO full:
  - Immediately `valid` = 0, `inst` = 0, `pc` = 0.
  - After release the sequence restarts at pc 0.
- With `INST_FETCH_BUBBLE_CNT_EN` defined: run the reset-release and one-redirect sequence; `bubble_cnt` = 3 (2 startup bubbles + 1 redirect bubble).
